// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: one bit per cycle (shift-add / restoring), results in HI/LO.
// Optional MD_EARLY_TERM_EN: multiply leaves CALC as soon as the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signed_in;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   diff;
    logic               borrow;
    logic [2*WIDTH-1:0] acc_add;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic               mul_last;
    logic               last_iter;

    assign signed_in = ~op[0];
    assign abs_a     = (signed_in && rsData[WIDTH-1]) ? -rsData : rsData;
    assign abs_b     = (signed_in && rtData[WIDTH-1]) ? -rtData : rtData;

    // Divide: the remainder lives in acc_q[WIDTH:0], dividend/quotient in mcand_q[WIDTH-1:0].
    assign rem_shift = {acc_q[WIDTH-1:0], mcand_q[WIDTH-1]};
    assign diff      = {1'b0, rem_shift} - {2'b00, b_q};
    assign borrow    = diff[WIDTH+1];

    // Multiply: multiplicand shifts left, multiplier shifts right.
    assign acc_add   = acc_q + (b_q[0] ? mcand_q : '0);

    assign prod      = neg_res_q ? -acc_q : acc_q;
    assign quot      = mcand_q[WIDTH-1:0];
    assign rem       = acc_q[WIDTH-1:0];

`ifdef MD_EARLY_TERM_EN
    assign mul_last  = (b_q[WIDTH-1:1] == '0);
`else
    assign mul_last  = 1'b0;
`endif

    assign last_iter = (cnt_q == CNT_W'(WIDTH-1)) || (!op_q[1] && mul_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (hiWrite) hi_d = writeData;
                if (loWrite) lo_d = writeData;
                if (start) begin
                    op_d      = op;
                    neg_res_d = signed_in & (rsData[WIDTH-1] ^ rtData[WIDTH-1]);
                    neg_rem_d = signed_in & op[1] & rsData[WIDTH-1];
                    acc_d     = '0;
                    mcand_d   = {{WIDTH{1'b0}}, abs_a};
                    b_d       = abs_b;
                    cnt_d     = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[1]) begin
                    acc_d          = '0;
                    acc_d[WIDTH:0] = borrow ? rem_shift : diff[WIDTH:0];
                    mcand_d        = {{WIDTH{1'b0}}, mcand_q[WIDTH-2:0], ~borrow};
                end else begin
                    acc_d   = acc_add;
                    mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
                    b_d     = {1'b0, b_q[WIDTH-1:1]};
                end
                if (last_iter) state_d = FIXUP;
            end
            FIXUP: begin
                if (op_q[1]) begin
                    lo_d = neg_res_q ? -quot : quot;
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random operations vs an arithmetic model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  rsData, rtData;
    logic          hiWrite, loWrite;
    logic [W-1:0]  writeData;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .rsData(rsData), .rtData(rtData), .hiWrite(hiWrite), .loWrite(loWrite),
        .writeData(writeData), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin q = sa * sb; res = q; end
            2'b01: res = {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 0) res = {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        logic [63:0] exp;
        int busy_cycles, done_cnt, done_at;
        logic [31:0] hi_at, lo_at;
        exp = model(o, a, b);
        busy_cycles = 0; done_cnt = 0; done_at = -1; hi_at = 'x; lo_at = 'x;
        @(negedge clock);
        start = 1'b1; op = o; rsData = a; rtData = b;
        @(posedge clock);
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (k == 0) start = 1'b0;
            if (inject && k == 10) begin
                start = 1'b1; op = 2'b00; rsData = 32'd3; rtData = 32'd3;
                hiWrite = 1'b1; writeData = 32'h12345678;
            end
            if (inject && k == 11) begin start = 1'b0; hiWrite = 1'b0; end
            if (!busy) break;
            busy_cycles++;
            if (done) begin done_cnt++; done_at = k; hi_at = hi; lo_at = lo; end
        end
        chk({tag, "_hi_at_done"}, {32'h0, hi_at}, {32'h0, exp[63:32]});
        chk({tag, "_lo_at_done"}, {32'h0, lo_at}, {32'h0, exp[31:0]});
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_done_cycle"}, 64'(done_at), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd34);
        chk({tag, "_final_hilo"}, {hi, lo}, exp);
        $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h done_at=%0d busy=%0d (%s)",
                 o, a, b, hi, lo, done_at, busy_cycles, tag);
    endtask

    initial begin
        logic [63:0] prev;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = 2'b00; rsData = '0; rtData = '0;
        hiWrite = 1'b0; loWrite = 1'b0; writeData = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_busy", {63'h0, busy}, 64'd0);
        chk("reset_done", {63'h0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'h0);
        reset = 1'b0;

        run_op("mult_neg", 2'b00, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        run_op("multu", 2'b01, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        run_op("divu", 2'b11, 32'd100, 32'd7, 1'b0);
        run_op("divu_by0", 2'b11, 32'h00000005, 32'h0, 1'b0);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op("div_by0_neg", 2'b10, 32'hFFFFFFF0, 32'h0, 1'b0);

        // Start and hiWrite while busy must both be dropped.
        run_op("divu_inject", 2'b11, 32'd1000, 32'd33, 1'b1);
        prev = {hi, lo};

        @(negedge clock);
        hiWrite = 1'b1; writeData = 32'h12345678;
        @(negedge clock);
        hiWrite = 1'b0;
        chk("idle_hiwrite_hi", {32'h0, hi}, 64'h12345678);
        chk("idle_hiwrite_lo", {32'h0, lo}, {32'h0, prev[31:0]});
        $display("mthi 12345678 -> hi=%h lo=%h", hi, lo);

        // Reset mid-multiply discards the partial result.
        start = 1'b1; op = 2'b00; rsData = 32'd12345; rtData = 32'd678;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        chk("midop_busy", {63'h0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        $display("reset mid-op -> busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);

        run_op("after_reset", 2'b00, 32'hFFFFFFFD, 32'd7, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op("rand", ro, ra, rb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle integer multiply/divide unit in the EX stage, directly downstream of the register bank. It consumes rsData/rtData for MULT, MULTU, DIV and DIVU and holds the results in architectural HI/LO registers. It resolves one bit per cycle (shift-add multiply, restoring divide) behind a start/busy/done handshake, so the pipeline control stalls on busy.

Parameters:
WIDTH, 32, operand width and HI/LO width in bits
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  launch operation; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rsData  input  WIDTH  operand A (multiplicand / dividend) from register bank
rtData  input  WIDTH  operand B (multiplier / divisor) from register bank
hiWrite  input  1  MTHI: write writeData to HI
loWrite  input  1  MTLO: write writeData to LO
writeData  input  WIDTH  data for MTHI/MTLO
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO updated by an operation
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Interface decision: reset reset, synchronous, active-high; clock clock.
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset overrides everything, including mid-operation; the partial result is discarded.
- FSM states: IDLE, CALC, FIXUP, DONE. busy=1 in CALC, FIXUP and DONE.
- IDLE: on an edge with start=1, latch op and operands, counter=0, go to CALC.
- Signed ops: latch absolute values. Record the result sign as signA xor signB. For DIV, also record the remainder sign as signA.
- CALC: one iteration per cycle, counter increments each cycle. After WIDTH cycles (counter=WIDTH-1 at the edge), go to FIXUP.
- Multiply: 2*WIDTH accumulator, shift-add of the unsigned magnitudes.
- Divide: restoring division with a WIDTH+1-bit partial remainder.
- FIXUP: apply the two's-complement negation needed for signed ops. Write the full product to {hi,lo}, or remainder to hi and quotient to lo. Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency: start edge = edge 0; hi/lo hold the result after edge WIDTH+1 (edge 33 at default); done is high in the cycle following that edge; busy drops after edge WIDTH+2.
- start while busy=1: ignored, no queuing.
- hiWrite/loWrite: take effect at the next edge only when busy=0. They are ignored while busy.
- hiWrite/loWrite in the same cycle as an accepted start: the write happens, and the operation result later overwrites it.
- Divide by zero: no trap. The natural restoring result is produced: quotient all ones, remainder = |A|, with the sign fixup still applied for DIV.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No exception.
- op values are fully decoded; there is no illegal op.

Optional Feature:
MD_EARLY_TERM_EN
- Defined: multiply CALC exits to FIXUP early when the remaining multiplier bits are all zero. Divide is unaffected. The minimum multiply latency is 2 cycles (start edge to HI/LO valid). done and busy timing track the shortened sequence.
- Undefined: every operation takes the fixed WIDTH+1 edges to result, as above.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFE; done pulses once; busy high for 34 cycles.
- MULTU rs=0xFFFFFFFF, rt=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=100, rt=7 -> lo=0x0000000E, hi=0x00000002.
- DIVU rs=0x00000005, rt=0 -> lo=0xFFFFFFFF, hi=0x00000005, no hang. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Second start (MULT 3*3) pulsed at cycle 10 of a running DIVU -> ignored; only the DIVU result appears, one done pulse. A hiWrite of 0x12345678 during busy is dropped; the same hiWrite while idle sets hi=0x12345678 next edge.
- reset asserted at cycle 15 of a MULT -> next edge busy=0, done=0, hi=lo=0. A new start right after reset completes normally with the correct result.
